// File: rtl/load_return_unit_if.sv
// load_return_unit_if: load request, data-memory read response and
// writeback/status signals of the load return unit.
// master = pipeline/memory side, slave = load_return_unit.
interface load_return_unit_if;
  logic        ld_valid;
  logic [2:0]  ld_type;
  logic [1:0]  addr_lo;
  logic [31:0] rt_old;
  logic        flush;
  logic [31:0] dm_rdata;
  logic        dm_rvalid;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        err_timeout;
  logic        err_adel;

  modport master (
    output ld_valid, ld_type, addr_lo, rt_old, flush, dm_rdata, dm_rvalid,
    input  stall, wb_valid, wb_data, err_timeout, err_adel
  );

  modport slave (
    input  ld_valid, ld_type, addr_lo, rt_old, flush, dm_rdata, dm_rvalid,
    output stall, wb_valid, wb_data, err_timeout, err_adel
  );
endinterface

// File: rtl/load_return_unit.sv
// load_return_unit: captures a load from M, stalls until the data-memory
// response returns, then aligns/extends/merges it into a one-cycle W beat.
// Optional macro LOAD_ALIGN_CHECK_EN: reject misaligned lw/lh/lhu with an
// err_adel pulse instead of issuing them.
//
// state   | meaning
// S_IDLE  | no load outstanding, accepting ld_valid
// S_WAIT  | load outstanding, waiting for dm_rvalid
// S_DRAIN | flushed load outstanding, discarding its response
module load_return_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic             clk,
  input logic             reset,
  load_return_unit_if.slave bus
);
  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_WAIT  = 2'd1;
  localparam logic [1:0]  S_DRAIN = 2'd2;
  localparam logic [15:0] TC      = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_type;
  logic [1:0]  r_k;
  logic [31:0] r_rt;
  logic        r_wb_valid;
  logic [31:0] r_wb_data;
  logic        r_err_timeout;
  logic        r_err_adel;

  logic        w_adel;
  logic        w_req;
  logic        w_accept;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [31:0] w_result;

`ifdef LOAD_ALIGN_CHECK_EN
  // Misaligned word/halfword loads are refused before memory is touched
  always_comb begin
    w_adel = 1'b0;
    case (bus.ld_type)
      3'd0, 3'd7: w_adel = (bus.addr_lo != 2'd0);
      3'd1, 3'd2: w_adel = bus.addr_lo[0];
      default:    w_adel = 1'b0;
    endcase
  end
`else
  assign w_adel = 1'b0;
`endif

  assign w_req    = (r_state == S_IDLE) & bus.ld_valid & ~bus.flush;
  assign w_accept = w_req & ~w_adel;

  assign bus.stall = w_accept
                   | ((r_state == S_WAIT) & ~bus.dm_rvalid)
                   | (r_state == S_DRAIN);

  // Lane selection and sign/zero extension or merge of the returned word
  always_comb begin
    w_half   = r_k[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];
    w_byte   = bus.dm_rdata[7:0];
    w_result = bus.dm_rdata;
    case (r_k)
      2'd0:    w_byte = bus.dm_rdata[7:0];
      2'd1:    w_byte = bus.dm_rdata[15:8];
      2'd2:    w_byte = bus.dm_rdata[23:16];
      default: w_byte = bus.dm_rdata[31:24];
    endcase
    case (r_type)
      3'd1: w_result = {{16{w_half[15]}}, w_half};
      3'd2: w_result = {16'h0000, w_half};
      3'd3: w_result = {{24{w_byte[7]}}, w_byte};
      3'd4: w_result = {24'h000000, w_byte};
      3'd5: begin
        case (r_k)
          2'd0:    w_result = {bus.dm_rdata[7:0],  r_rt[23:0]};
          2'd1:    w_result = {bus.dm_rdata[15:0], r_rt[15:0]};
          2'd2:    w_result = {bus.dm_rdata[23:0], r_rt[7:0]};
          default: w_result = bus.dm_rdata;
        endcase
      end
      3'd6: begin
        case (r_k)
          2'd0:    w_result = bus.dm_rdata;
          2'd1:    w_result = {r_rt[31:24], bus.dm_rdata[31:8]};
          2'd2:    w_result = {r_rt[31:16], bus.dm_rdata[31:16]};
          default: w_result = {r_rt[31:8],  bus.dm_rdata[31:24]};
        endcase
      end
      default: w_result = bus.dm_rdata;
    endcase
  end

  // Sequencing FSM, wait counter and registered result/status beats
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= 16'd0;
      r_type        <= 3'd0;
      r_k           <= 2'd0;
      r_rt          <= 32'd0;
      r_wb_valid    <= 1'b0;
      r_wb_data     <= 32'd0;
      r_err_timeout <= 1'b0;
      r_err_adel    <= 1'b0;
    end else begin
      r_wb_valid    <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_adel    <= w_req & w_adel;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_type  <= bus.ld_type;
            r_k     <= bus.addr_lo;
            r_rt    <= bus.rt_old;
            r_cnt   <= 16'd0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.flush) begin
            // a flushed load still owes one response; drain it unless it is here now
            r_cnt   <= r_cnt + 16'd1;
            r_state <= bus.dm_rvalid ? S_IDLE : S_DRAIN;
          end else if (bus.dm_rvalid) begin
            r_wb_valid <= 1'b1;
            r_wb_data  <= w_result;
            r_state    <= S_IDLE;
          end else if (r_cnt == TC) begin
            r_err_timeout <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DRAIN: begin
          // count may already be past TC if the flush landed on the last wait cycle
          if (bus.dm_rvalid || (r_cnt >= TC)) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.wb_valid    = r_wb_valid;
  assign bus.wb_data     = r_wb_data;
  assign bus.err_timeout = r_err_timeout;
  assign bus.err_adel    = r_err_adel;
endmodule

// File: tb/tb_load_return_unit.sv
// Testbench for load_return_unit: directed loads with literal expectations
// plus randomized traffic checked every cycle against a transaction model.
module tb_load_return_unit;
  localparam int T = 4;
`ifdef LOAD_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_return_unit_if bus();
  load_return_unit #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] t, input logic [1:0] k,
                                             input logic [31:0] rt, input logic [31:0] d);
    int sh;
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] ones;
    sh   = 8 * int'(k);
    ones = '1;
    h    = 16'(d >> (16 * int'(k[1])));
    b    = 8'(d >> sh);
    case (t)
      3'd1: return 32'($signed(h));
      3'd2: return {16'h0, h};
      3'd3: return 32'($signed(b));
      3'd4: return {24'h0, b};
      3'd5: if (k == 2'd3) return d;
            else return (d << (24 - sh)) | (rt & (ones >> (sh + 8)));
      3'd6: return (d >> sh) | (rt & ~(ones >> sh));
      default: return d;
    endcase
  endfunction

  function automatic bit misaligned(input logic [2:0] t, input logic [1:0] k);
    if (t == 3'd0 || t == 3'd7) return k != 2'd0;
    if (t == 3'd1 || t == 3'd2) return k[0];
    return 1'b0;
  endfunction

  // Transaction model: one outstanding load, its age, and whether it was killed
  bit          m_busy, m_dead;
  int          m_n;
  logic [2:0]  m_t;
  logic [1:0]  m_k;
  logic [31:0] m_rt;
  logic        e_wb_valid, e_to, e_adel;
  logic [31:0] e_wb_data;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_dead = 0; m_n = 0;
      e_wb_valid = 0; e_to = 0; e_adel = 0; e_wb_data = 0;
    end else begin
      e_wb_valid = 0; e_to = 0; e_adel = 0;
      if (!m_busy) begin
        if (bus.ld_valid && !bus.flush) begin
          if (ALIGN && misaligned(bus.ld_type, bus.addr_lo)) e_adel = 1;
          else begin
            m_busy = 1; m_dead = 0; m_n = 0;
            m_t = bus.ld_type; m_k = bus.addr_lo; m_rt = bus.rt_old;
          end
        end
      end else if (!m_dead) begin
        m_n++;
        if (bus.flush) begin
          if (bus.dm_rvalid) m_busy = 0; else m_dead = 1;
        end else if (bus.dm_rvalid) begin
          e_wb_valid = 1; e_wb_data = ref_result(m_t, m_k, m_rt, bus.dm_rdata); m_busy = 0;
        end else if (m_n == T) begin
          e_to = 1; m_busy = 0;
        end
      end else begin
        m_n++;
        if (bus.dm_rvalid || m_n >= T) m_busy = 0;
      end
    end
  end

  function automatic logic exp_stall();
    if (!m_busy)
      return bus.ld_valid && !bus.flush && !(ALIGN && misaligned(bus.ld_type, bus.addr_lo));
    if (m_dead) return 1'b1;
    return !bus.dm_rvalid;
  endfunction

  int stall_cnt, wb_cnt, to_cnt, adel_cnt;
  always @(negedge clk) begin
    if (bus.stall)       stall_cnt++;
    if (bus.wb_valid)    wb_cnt++;
    if (bus.err_timeout) to_cnt++;
    if (bus.err_adel)    adel_cnt++;
    if (chk_en && !reset) begin
      chk("model stall",       bus.stall,       exp_stall());
      chk("model wb_valid",    bus.wb_valid,    e_wb_valid);
      chk("model wb_data",     bus.wb_data,     e_wb_data);
      chk("model err_timeout", bus.err_timeout, e_to);
      chk("model err_adel",    bus.err_adel,    e_adel);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ld_valid = 0; bus.ld_type = 0; bus.addr_lo = 0; bus.rt_old = 0;
    bus.flush = 0; bus.dm_rdata = 0; bus.dm_rvalid = 0;
  endtask

  // lat = cycles from ld_valid to dm_rvalid (1 = first WAIT cycle)
  task automatic directed_load(input string name, input logic [2:0] t, input logic [1:0] k,
                               input logic [31:0] rt, input logic [31:0] d, input int lat,
                               input logic [31:0] expv);
    stall_cnt = 0;
    bus.ld_valid = 1; bus.ld_type = t; bus.addr_lo = k; bus.rt_old = rt;
    tick();
    bus.ld_valid = 0;
    repeat (lat - 1) tick();
    bus.dm_rvalid = 1; bus.dm_rdata = d;
    tick();
    bus.dm_rvalid = 0; bus.dm_rdata = 32'hDEAD_BEEF;
    chk({name, " wb_valid"}, bus.wb_valid, 1'b1);
    chk({name, " wb_data"},  bus.wb_data,  expv);
    chk({name, " stall cycles"}, stall_cnt, lat);
    tick();
    chk({name, " wb_valid drop"}, bus.wb_valid, 1'b0);
    chk({name, " wb_data hold"},  bus.wb_data,  expv);
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    repeat (2) tick();
    reset = 0;
    chk_en = 1;
    chk("reset wb_valid",    bus.wb_valid,    1'b0);
    chk("reset wb_data",     bus.wb_data,     32'h0);
    chk("reset stall",       bus.stall,       1'b0);
    chk("reset err_timeout", bus.err_timeout, 1'b0);
    chk("reset err_adel",    bus.err_adel,    1'b0);

    directed_load("lb k2",  3'd3, 2'd2, 32'h0, 32'h12F45678, 3, 32'hFFFFFFF4);
    directed_load("lbu k2", 3'd4, 2'd2, 32'h0, 32'h12F45678, 3, 32'h000000F4);
    directed_load("lh k2",  3'd1, 2'd2, 32'h0, 32'h80017FFF, 1, 32'hFFFF8001);
    directed_load("lhu k2", 3'd2, 2'd2, 32'h0, 32'h80017FFF, 1, 32'h00008001);
    directed_load("lw k0",  3'd0, 2'd0, 32'h0, 32'h80017FFF, 1, 32'h80017FFF);
    directed_load("lwl k1", 3'd5, 2'd1, 32'hAABBCCDD, 32'h11223344, 1, 32'h3344CCDD);
    directed_load("lwr k1", 3'd6, 2'd1, 32'hAABBCCDD, 32'h11223344, 1, 32'hAA112233);
    directed_load("lb k3",  3'd3, 2'd3, 32'h0, 32'h7F000000, 2, 32'h0000007F);

    // flush in second WAIT cycle, stale response two cycles later
    stall_cnt = 0; wb_cnt = 0;
    bus.ld_valid = 1; bus.ld_type = 3'd3; bus.addr_lo = 2'd0; tick();
    bus.ld_valid = 0; tick();
    bus.flush = 1; tick();
    bus.flush = 0; tick();
    bus.dm_rvalid = 1; bus.dm_rdata = 32'h000000AA; tick();
    bus.dm_rvalid = 0;
    chk("flush wb count", wb_cnt, 0);
    chk("flush stall cycles", stall_cnt, 5);
    chk("flush stall after drain", bus.stall, 1'b0);
    directed_load("lb after flush", 3'd3, 2'd2, 32'h0, 32'h12F45678, 1, 32'hFFFFFFF4);

    // timeout with no response
    stall_cnt = 0; to_cnt = 0; wb_cnt = 0;
    bus.ld_valid = 1; bus.ld_type = 3'd0; bus.addr_lo = 2'd0; tick();
    bus.ld_valid = 0;
    repeat (T) tick();
    chk("timeout pulse", bus.err_timeout, 1'b1);
    chk("timeout stall low", bus.stall, 1'b0);
    tick();
    chk("timeout pulse drop", bus.err_timeout, 1'b0);
    chk("timeout pulse count", to_cnt, 1);
    chk("timeout stall cycles", stall_cnt, T + 1);
    chk("timeout wb count", wb_cnt, 0);
    directed_load("lhu after timeout", 3'd2, 2'd0, 32'h0, 32'h0000ABCD, 1, 32'h0000ABCD);

    // misaligned lw
    stall_cnt = 0; adel_cnt = 0; wb_cnt = 0;
`ifdef LOAD_ALIGN_CHECK_EN
    bus.ld_valid = 1; bus.ld_type = 3'd0; bus.addr_lo = 2'd2; tick();
    bus.ld_valid = 0;
    chk("adel pulse", bus.err_adel, 1'b1);
    tick();
    chk("adel pulse drop", bus.err_adel, 1'b0);
    chk("adel pulse count", adel_cnt, 1);
    chk("adel stall cycles", stall_cnt, 0);
    chk("adel wb count", wb_cnt, 0);
    directed_load("lh k2 after adel", 3'd1, 2'd2, 32'h0, 32'h80017FFF, 1, 32'hFFFF8001);
`else
    directed_load("lw k2 unchecked", 3'd0, 2'd2, 32'h0, 32'h80017FFF, 1, 32'h80017FFF);
    chk("adel never", adel_cnt, 0);
`endif

    // reset mid-load; late response must be ignored
    wb_cnt = 0;
    bus.ld_valid = 1; bus.ld_type = 3'd0; bus.addr_lo = 2'd0; tick();
    bus.ld_valid = 0; tick();
    reset = 1; tick();
    reset = 0;
    chk("reset mid stall", bus.stall, 1'b0);
    bus.dm_rvalid = 1; bus.dm_rdata = 32'h55555555; tick();
    bus.dm_rvalid = 0; tick();
    chk("late rvalid ignored", wb_cnt, 0);
    chk("reset mid wb_data", bus.wb_data, 32'h0);

    // randomized traffic, checked by the per-cycle model compare
    for (int i = 0; i < 4000; i++) begin
      reset         = ($urandom_range(0, 299) == 0);
      bus.ld_valid  = ($urandom_range(0, 99) < 40);
      bus.ld_type   = 3'($urandom_range(0, 7));
      bus.addr_lo   = 2'($urandom_range(0, 3));
      bus.rt_old    = $urandom;
      bus.flush     = ($urandom_range(0, 99) < 8);
      bus.dm_rvalid = ($urandom_range(0, 99) < 30);
      bus.dm_rdata  = $urandom;
      tick();
    end
    reset = 0;
    clear_inputs();
    repeat (T + 3) tick();
    chk("final idle stall", bus.stall, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/load_return_unit.md
Name: load_return_unit

Overview:
- Load-side counterpart of the M-stage store control. Store control drives write enable and byte-lane selects into data memory; this block consumes the data-memory read response for loads.
- Captures the load request from M, stalls the pipeline until the read data returns, then byte-aligns, sign/zero-extends or merges (lwl/lwr) the data.
- Presents a one-cycle result beat to W for rt writeback.
- Handles flush of an in-flight load and detects a memory timeout.

Parameters:
- TIMEOUT_CYCLES, 255: WAIT cycles without dm_rvalid before err_timeout; range 1..65535.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- ld_valid  in  1  M stage issues a load this cycle
- ld_type  in  3  0=lw 1=lh 2=lhu 3=lb 4=lbu 5=lwl 6=lwr 7=reserved (treated as lw)
- addr_lo  in  2  byte address [1:0] of the load
- rt_old  in  32  current rt value (merge source for lwl/lwr)
- flush  in  1  kill the in-flight/incoming load
- dm_rdata  in  32  word read from data memory, little-endian lanes
- dm_rvalid  in  1  dm_rdata valid, one-cycle pulse per request
- stall  out  1  freeze F/D/E/M
- wb_valid  out  1  one-cycle result strobe
- wb_data  out  32  aligned/extended result
- err_timeout  out  1  one-cycle pulse on timeout
- err_adel  out  1  misaligned-load pulse (optional feature only)

Behaviour:
- Reset values: state=IDLE; wb_valid, wb_data, err_timeout, err_adel, and wait counter all 0.
- FSM states: IDLE, WAIT, DRAIN.
- IDLE:
  - ld_valid & !flush: capture ld_type, addr_lo, rt_old; clear counter; go WAIT.
  - dm_rvalid in IDLE is ignored.
- WAIT:
  - dm_rvalid & !flush: next cycle wb_valid=1 and wb_data=f(type, addr_lo, dm_rdata, rt_old); go IDLE.
  - flush & !dm_rvalid: go DRAIN, no wb_valid.
  - flush & dm_rvalid: flush wins, response consumed, go IDLE, no wb_valid.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 with no rvalid: err_timeout pulses next cycle, go IDLE, no wb_valid.
- DRAIN: wait for the stale dm_rvalid, discard it, go IDLE. Flush has no effect in DRAIN. The timeout counter runs in DRAIN too; timeout there returns to IDLE silently, with no err_timeout.
- ld_valid is ignored outside IDLE.
- stall = (IDLE & ld_valid & !flush) | (WAIT & !dm_rvalid) | DRAIN. Stall is combinational.
- Latency: the result appears the cycle after dm_rvalid. Minimum is 2 cycles from ld_valid (rvalid in the first WAIT cycle).
- wb_valid is high for exactly one cycle. wb_data holds its value until the next result.
- Extraction (k = captured addr_lo, B[n] = dm_rdata byte n):
  - lw: dm_rdata.
  - lh/lhu: halfword at bits [16*k[1]+15 : 16*k[1]], sign-/zero-extended.
  - lb/lbu: B[k], sign-/zero-extended.
  - lwl:
    - k=0: {B0, rt[23:0]}
    - k=1: {B1,B0, rt[15:0]}
    - k=2: {B2,B1,B0, rt[7:0]}
    - k=3: dm_rdata
  - lwr:
    - k=0: dm_rdata
    - k=1: {rt[31:24], B3,B2,B1}
    - k=2: {rt[31:16], B3,B2}
    - k=3: {rt[31:8], B3}
- Without the optional feature, misalignment for lw/lh/lhu is not checked: lw ignores k; lh uses k[1] only.
- Reset mid-operation returns to IDLE immediately. A late dm_rvalid after reset is ignored.

Optional Feature:
- Macro: LOAD_ALIGN_CHECK_EN.
- Defined:
  - In IDLE, a load that would be accepted (ld_valid & !flush) with a misaligned address (lw/type 7 with k!=0, or lh/lhu with k[0]=1) does not enter WAIT.
  - err_adel pulses the next cycle; no stall, no wb_valid. Memory must not be awaited.
- Not defined: err_adel is tied to 0 and misaligned loads proceed as described under Behaviour.

Test Plan:
- lb, k=2, dm_rdata=0x12F45678, rvalid 3 cycles after ld_valid → stall high 3 cycles, wb_valid one cycle later, wb_data=0xFFFFFFF4. Same with lbu → 0x000000F4.
- lh, k=2, dm_rdata=0x80017FFF → 0xFFFF8001. lhu → 0x00008001. lw, k=0 → 0x80017FFF. All with rvalid in the first WAIT cycle, so wb_valid at cycle+2.
- lwl, k=1, rt_old=0xAABBCCDD, dm_rdata=0x11223344 → 0x3344CCDD. lwr, k=1 → 0xAA112233.
- flush in the second WAIT cycle, rvalid 2 cycles later → no wb_valid, stall until rvalid is discarded. A new lb issued the next IDLE cycle returns correct data.
- TIMEOUT_CYCLES=4, no rvalid → exactly one err_timeout pulse after 4 WAIT cycles, state IDLE, stall low.
- With LOAD_ALIGN_CHECK_EN: lw, k=2 → err_adel pulse the next cycle, stall never asserted, wb_valid 0. Then lh, k=2 completes normally.
